// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared constants for the DAC thermometer sequencer
package dac_pkg;

  localparam int LFSR_WIDTH = 16;

  // x^16+x^14+x^13+x^11+1 as a left-shifting Fibonacci LFSR: taps at bits 15,13,12,10
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/dac_binary_to_thermometer.sv
// rtl/dac_binary_to_thermometer.sv - combinational binary code to thermometer decoder
module dac_binary_to_thermometer #(
  parameter  int THERMOMETER_WIDTH = 256,
  localparam int BINARY_WIDTH      = $clog2(THERMOMETER_WIDTH)
) (
  input  logic [BINARY_WIDTH-1:0]      i_code,
  output logic [THERMOMETER_WIDTH-1:0] o_thermometer
);

  // Bit k is on when the code exceeds k, so code N lights bits 0..N-1.
  for (genvar gi = 0; gi < THERMOMETER_WIDTH; gi++) begin : g_bit
    assign o_thermometer[gi] = (i_code > BINARY_WIDTH'(gi));
  end

endmodule

// File: rtl/dac_thermometer_sequencer.sv
// rtl/dac_thermometer_sequencer.sv - thermometer feeder with rotation index; DAC_THERM_SEQ_LFSR_EN selects LFSR index
module dac_thermometer_sequencer
  import dac_pkg::*;
#(
  parameter  int THERMOMETER_WIDTH = 256,
  parameter  int INDEX_WIDTH       = 4,
  localparam int BINARY_WIDTH      = $clog2(THERMOMETER_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [INDEX_WIDTH-1:0]       index_step,
  input  logic                         index_clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BINARY_WIDTH-1:0]      in_code,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [THERMOMETER_WIDTH-1:0] output_thermometer,
  output logic [INDEX_WIDTH-1:0]       cycle_index
);

  logic                         r_out_valid;
  logic [THERMOMETER_WIDTH-1:0] r_thermometer;
  logic [INDEX_WIDTH-1:0]       r_cycle_index;
  logic                         w_accept;
  logic [THERMOMETER_WIDTH-1:0] w_decoded;
  logic [INDEX_WIDTH-1:0]       w_index_now;

  assign in_ready           = enable & (~r_out_valid | out_ready);
  assign w_accept           = in_valid & in_ready;
  assign out_valid          = r_out_valid;
  assign output_thermometer = r_thermometer;
  assign cycle_index        = r_cycle_index;

  dac_binary_to_thermometer #(
    .THERMOMETER_WIDTH(THERMOMETER_WIDTH)
  ) u_decoder (
    .i_code        (in_code),
    .o_thermometer (w_decoded)
  );

  // A new accept overwrites the held word; otherwise a completed handshake empties the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_thermometer <= '0;
      r_cycle_index <= '0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_thermometer <= w_decoded;
      r_cycle_index <= w_index_now;
    end else if (out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

`ifdef DAC_THERM_SEQ_LFSR_EN
  logic [LFSR_WIDTH-1:0] r_lfsr;
  logic                  w_feedback;
  logic                  w_unused_step;

  assign w_feedback    = ^(r_lfsr & LFSR_TAPS);
  assign w_index_now   = r_lfsr[INDEX_WIDTH-1:0];
  assign w_unused_step = ^index_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (index_clear) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[LFSR_WIDTH-2:0], w_feedback};
    end
  end
`else
  logic [INDEX_WIDTH-1:0] r_index;

  assign w_index_now = r_index;

  // Modular add wraps naturally at 2**INDEX_WIDTH; clear wins over the step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index <= '0;
    end else if (index_clear) begin
      r_index <= '0;
    end else if (w_accept) begin
      r_index <= r_index + index_step;
    end
  end
`endif

endmodule
